// File: rtl/pipe_rr_arbiter_pkg.sv
// Shared types for the pipeline arbiter: handshake FSM states and a tag-width helper.
package pipe_arb_pkg;

  typedef enum logic [1:0] {
    IN_IDLE = 2'd0,
    IN_REQ  = 2'd1,
    IN_REL  = 2'd2
  } in_state_t;

  typedef enum logic {
    OUT_IDLE = 1'b0,
    OUT_ACK  = 1'b1
  } out_state_t;

  // Index width for n entries, never narrower than one bit.
  function automatic int tag_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pipe_rr_arbiter_if.sv
// Client and asynchronous-pipeline signals of the arbiter, bundled with directional views.
interface pipe_rr_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 3
);
  logic [NREQ-1:0]    cli_valid;
  logic [NREQ*DW-1:0] cli_data;
  logic [NREQ-1:0]    cli_ready;
  logic [NREQ-1:0]    rsp_valid;
  logic [DW-1:0]      rsp_data;
  logic               pipe_rst_n;
  logic               pipe_req_in;
  logic [DW-1:0]      pipe_data_in;
  logic               pipe_ack_out;
  logic               pipe_req_out;
  logic [DW-1:0]      pipe_data_out;
  logic               pipe_ack_in;
  logic               busy;
  logic               err_orphan;

  // Arbiter side.
  modport master (
    input  cli_valid, cli_data, pipe_ack_out, pipe_req_out, pipe_data_out,
    output cli_ready, rsp_valid, rsp_data, pipe_rst_n, pipe_req_in, pipe_data_in,
           pipe_ack_in, busy, err_orphan
  );

  // Clients plus pipeline side.
  modport slave (
    output cli_valid, cli_data, pipe_ack_out, pipe_req_out, pipe_data_out,
    input  cli_ready, rsp_valid, rsp_data, pipe_rst_n, pipe_req_in, pipe_data_in,
           pipe_ack_in, busy, err_orphan
  );
endinterface

// File: rtl/pipe_rr_arbiter_sync_2ff.sv
// Multi-flop synchronizer for one asynchronous handshake line, cleared by synchronous reset.
module sync_2ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);
  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (rst) r_sync <= '0;
    else     r_sync <= {r_sync[STAGES-2:0], i_d};
  end

  assign o_q = r_sync[STAGES-1];
endmodule

// File: rtl/pipe_rr_arbiter.sv
// Round-robin front-end sharing one 4-phase req/ack pipeline among NREQ clients;
// a tag FIFO routes each in-order result back to the client that issued it.
module pipe_rr_arbiter
  import pipe_arb_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int DW          = 3,
  parameter int SYNC_STAGES = 2,
  parameter int TAG_DEPTH   = 8
) (
  input logic              clk,
  input logic              rst,
  pipe_rr_arbiter_if.master bus
);
  localparam int TW = tag_w(NREQ);
  localparam int PW = tag_w(TAG_DEPTH);
  localparam int CW = PW + 1;

  logic w_ack_s, w_req_s;

  sync_2ff #(.STAGES(SYNC_STAGES)) u_sync_ack (
    .clk (clk), .rst (rst), .i_d (bus.pipe_ack_out), .o_q (w_ack_s)
  );
  sync_2ff #(.STAGES(SYNC_STAGES)) u_sync_req (
    .clk (clk), .rst (rst), .i_d (bus.pipe_req_out), .o_q (w_req_s)
  );

  in_state_t       r_in_state, w_in_next;
  out_state_t      r_out_state, w_out_next;
  logic [TW-1:0]   r_rr_ptr;
  logic [TW-1:0]   w_cand;
  logic [TW-1:0]   w_grant_idx;
  logic            w_grant_any;
  logic            w_grant;
  logic [PW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic [TW-1:0]   r_tag_mem [TAG_DEPTH];
  logic            w_full, w_empty;
  logic            w_res_start, w_pop, w_orphan;
  logic            r_req_s_d;
  logic            r_req_in, r_ack_in, r_err, r_pipe_rst_n;
  logic [DW-1:0]   r_data_in, r_rsp_data;
  logic [NREQ-1:0] r_rsp_valid;
  logic [NREQ-1:0] w_rsp_onehot;

  assign w_full  = (r_count == CW'(TAG_DEPTH));
  assign w_empty = (r_count == '0);

  // Lowest offset from rr_ptr wins; scanning downward leaves that one last.
  always_comb begin
    w_grant_any = 1'b0;
    w_grant_idx = '0;
    w_cand      = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_cand = TW'((int'(r_rr_ptr) + k) % NREQ);
      if (bus.cli_valid[w_cand]) begin
        w_grant_any = 1'b1;
        w_grant_idx = w_cand;
      end
    end
  end

  // Input FSM: state register, next state, combinational accept.
  always_ff @(posedge clk) begin
    if (rst) r_in_state <= IN_IDLE;
    else     r_in_state <= w_in_next;
  end

  always_comb begin
    w_in_next = r_in_state;
    case (r_in_state)
      IN_IDLE: if (w_grant)  w_in_next = IN_REQ;
      IN_REQ:  if (w_ack_s)  w_in_next = IN_REL;
      IN_REL:  if (!w_ack_s) w_in_next = IN_IDLE;
      default:               w_in_next = IN_IDLE;
    endcase
  end

  always_comb begin
    w_grant       = (r_in_state == IN_IDLE) && !w_full && w_grant_any && !rst;
    bus.cli_ready = w_grant ? ({{(NREQ-1){1'b0}}, 1'b1} << w_grant_idx) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_req_in  <= 1'b0;
      r_data_in <= '0;
      r_rr_ptr  <= '0;
    end else begin
      if (w_grant) begin
        r_data_in <= bus.cli_data[int'(w_grant_idx)*DW +: DW];
        r_rr_ptr  <= (w_grant_idx == TW'(NREQ - 1)) ? '0 : w_grant_idx + 1'b1;
      end
      r_req_in <= (w_in_next == IN_REQ);
    end
  end

  // Output FSM: state register, next state, result/orphan decode.
  always_ff @(posedge clk) begin
    if (rst) r_out_state <= OUT_IDLE;
    else     r_out_state <= w_out_next;
  end

  always_comb begin
    w_out_next = r_out_state;
    case (r_out_state)
      OUT_IDLE: if (w_res_start) w_out_next = OUT_ACK;
      OUT_ACK:  if (!w_req_s)    w_out_next = OUT_IDLE;
      default:                   w_out_next = OUT_IDLE;
    endcase
  end

  always_comb begin
    w_res_start  = (r_out_state == OUT_IDLE) && w_req_s && !r_req_s_d;
    w_pop        = w_res_start && !w_empty;
    w_orphan     = w_res_start && w_empty;
    w_rsp_onehot = {{(NREQ-1){1'b0}}, 1'b1} << r_tag_mem[r_rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_req_s_d    <= 1'b0;
      r_ack_in     <= 1'b0;
      r_rsp_valid  <= '0;
      r_rsp_data   <= '0;
      r_err        <= 1'b0;
      r_pipe_rst_n <= 1'b0;
    end else begin
      r_req_s_d    <= w_req_s;
      r_ack_in     <= (w_out_next == OUT_ACK);
      r_rsp_valid  <= w_pop ? w_rsp_onehot : '0;
      r_pipe_rst_n <= 1'b1;
      if (w_res_start) r_rsp_data <= bus.pipe_data_out;
      if (w_orphan)    r_err      <= 1'b1;
    end
  end

  // Tag FIFO: a grant pushes, a result pops; both in one cycle keep the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_grant) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_grant, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_grant) r_tag_mem[r_wr_ptr] <= w_grant_idx;
  end

  assign bus.pipe_rst_n   = r_pipe_rst_n;
  assign bus.pipe_req_in  = r_req_in;
  assign bus.pipe_data_in = r_data_in;
  assign bus.pipe_ack_in  = r_ack_in;
  assign bus.rsp_valid    = r_rsp_valid;
  assign bus.rsp_data     = r_rsp_data;
  assign bus.err_orphan   = r_err;
  assign bus.busy         = !w_empty || (r_in_state != IN_IDLE) || (r_out_state != OUT_IDLE);

endmodule

// File: tb/tb_pipe_rr_arbiter.sv
// Bench for pipe_rr_arbiter: random-delay 4-phase FIFO pipeline model, queue-based
// issue/response reference and directed steps for arbitration, full, reset and orphan cases.
module tb_pipe_rr_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 3;
  localparam int SS   = 2;
  localparam int TD   = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pipe_rr_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();

  pipe_rr_arbiter #(.NREQ(NREQ), .DW(DW), .SYNC_STAGES(SS), .TAG_DEPTH(TD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- client sources ----------------
  int src_left [NREQ];
  int fix_data [NREQ];
  logic [NREQ-1:0] took = '0;

  always @(posedge clk) begin
    #2;
    for (int i = 0; i < NREQ; i++) begin
      if (took[i]) src_left[i]--;
      if (src_left[i] > 0) begin
        if (took[i] || bus.cli_valid[i] !== 1'b1)
          bus.cli_data[i*DW +: DW] = (fix_data[i] >= 0) ? DW'(fix_data[i]) : DW'($urandom);
        bus.cli_valid[i] = 1'b1;
      end else begin
        bus.cli_valid[i] = 1'b0;
      end
    end
  end

  // ---------------- pipeline model: FIFO with random handshake delays ----------------
  int   pq [$];
  int   pin_st = 0, pin_cnt = 0, pout_st = 0, pout_cnt = 0;
  int   maxd = 20;
  bit   stall_out = 0, inj_orphan = 0, pout_orphan = 0;
  time  t_req_rise = 0;

  always @(negedge clk) begin
    if (bus.pipe_rst_n !== 1'b1) begin
      pq.delete();
      pin_st = 0; pout_st = 0;
      bus.pipe_ack_out  = 1'b0;
      bus.pipe_req_out  = 1'b0;
      bus.pipe_data_out = '0;
    end else begin
      case (pin_st)
        0: if (bus.pipe_req_in) begin pin_cnt = $urandom_range(maxd, 1); pin_st = 1; end
        1: if (pin_cnt > 1) pin_cnt--;
           else begin pq.push_back(int'(bus.pipe_data_in)); bus.pipe_ack_out = 1'b1; pin_st = 2; end
        2: if (!bus.pipe_req_in) begin pin_cnt = $urandom_range(maxd, 1); pin_st = 3; end
        3: if (pin_cnt > 1) pin_cnt--;
           else begin bus.pipe_ack_out = 1'b0; pin_st = 0; end
        default: pin_st = 0;
      endcase
      case (pout_st)
        0: if (inj_orphan) begin
             inj_orphan = 0; pout_orphan = 1; pout_cnt = $urandom_range(maxd, 1); pout_st = 1;
           end else if (pq.size() > 0 && !stall_out) begin
             pout_orphan = 0; pout_cnt = $urandom_range(maxd, 1); pout_st = 1;
           end
        1: if (pout_cnt > 1) pout_cnt--;
           else begin
             bus.pipe_data_out = pout_orphan ? DW'(6) : DW'(pq[0]);
             bus.pipe_req_out  = 1'b1;
             t_req_rise        = $time;
             pout_st           = 2;
           end
        2: if (bus.pipe_ack_in) begin
             if (!pout_orphan) void'(pq.pop_front());
             pout_cnt = $urandom_range(maxd, 1); pout_st = 3;
           end
        3: if (pout_cnt > 1) pout_cnt--;
           else begin bus.pipe_req_out = 1'b0; pout_st = 4; end
        4: if (!bus.pipe_ack_in) pout_st = 0;
        default: pout_st = 0;
      endcase
    end
  end

  // ---------------- reference: round-robin issue order and in-order return ----------------
  typedef struct { int cli; int data; } ent_t;
  ent_t exp_q [$];
  int   grant_log [$];
  int   exp_ptr = 0, pp_cnt = 0, rsp_cnt = 0, last_data = 0, g = 0;
  bit   prev_req_in = 0, prev_grant = 0;
  ent_t e;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete(); grant_log.delete();
      exp_ptr = 0; took = '0; prev_req_in = 0; prev_grant = 0;
    end else begin
      if (bus.rsp_valid !== '0) begin
        rsp_cnt++;
        if (prev_grant) pp_cnt++;
        if (exp_q.size() == 0) check("rsp_with_nothing_issued", bus.rsp_valid, 0);
        else begin
          e = exp_q.pop_front();
          check("rsp_valid_route", bus.rsp_valid, 32'(1) << e.cli);
          check("rsp_data", bus.rsp_data, e.data);
        end
      end
      if (bus.pipe_req_in && !prev_req_in) check("pipe_data_in_at_req", bus.pipe_data_in, last_data);
      prev_req_in = bus.pipe_req_in;
      prev_grant  = 0;
      if (bus.cli_ready !== '0) begin
        g = -1;
        for (int k = 0; k < NREQ; k++)
          if (g < 0 && bus.cli_valid[(exp_ptr + k) % NREQ]) g = (exp_ptr + k) % NREQ;
        if (g < 0) check("ready_without_valid", bus.cli_ready, 0);
        else begin
          check("rr_grant", bus.cli_ready, 32'(1) << g);
          check("grant_while_full", exp_q.size() < TD, 1);
          last_data = int'(bus.cli_data[g*DW +: DW]);
          exp_q.push_back('{cli: g, data: last_data});
          grant_log.push_back(g);
          exp_ptr    = (g + 1) % NREQ;
          prev_grant = 1;
        end
      end
      took = bus.cli_valid & bus.cli_ready;
    end
  end

  function automatic int left_total();
    int s = 0;
    for (int i = 0; i < NREQ; i++) s += src_left[i];
    return s;
  endfunction

  task automatic wait_drain(input string tag, input int lim);
    int n = 0;
    while ((left_total() != 0 || exp_q.size() != 0 || bus.busy !== 1'b0) && n < lim) begin
      @(negedge clk); n++;
    end
    check({tag, "_drain_in_time"}, n < lim, 1);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int r0;
    for (int i = 0; i < NREQ; i++) begin src_left[i] = 0; fix_data[i] = -1; end

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cli_ready",  bus.cli_ready, 0);
    check("rst_rsp_valid",  bus.rsp_valid, 0);
    check("rst_req_in",     bus.pipe_req_in, 0);
    check("rst_ack_in",     bus.pipe_ack_in, 0);
    check("rst_pipe_rst_n", bus.pipe_rst_n, 0);
    check("rst_busy",       bus.busy, 0);
    check("rst_err",        bus.err_orphan, 0);
    rst = 1'b0;
    @(negedge clk);
    check("pipe_rst_n_rise", bus.pipe_rst_n, 1);

    // 1: single client 0 sends 5
    fix_data[0] = 5; src_left[0] = 1;
    n = 0; while (bus.cli_ready === '0 && n < 50) begin @(negedge clk); n++; end
    check("t1_ready", bus.cli_ready, 4'b0001);
    @(negedge clk);
    check("t1_req_in", bus.pipe_req_in, 1);
    check("t1_data_in", bus.pipe_data_in, 5);
    n = 0; while (bus.rsp_valid === '0 && n < 200) begin @(negedge clk); n++; end
    check("t1_rsp_valid", bus.rsp_valid, 4'b0001);
    check("t1_rsp_data", bus.rsp_data, 5);
    check("t1_latency", ($time - t_req_rise) / 10, SS + 1);
    @(negedge clk);
    check("t1_rsp_one_cycle", bus.rsp_valid, 0);
    fix_data[0] = -1;
    wait_drain("t1", 300);

    // 2: all clients continuously valid
    grant_log.delete();
    for (int i = 0; i < NREQ; i++) src_left[i] = 6;
    wait_drain("t2", 4000);
    check("t2_grants", grant_log.size(), 24);
    for (int k = 1; k < grant_log.size(); k++)
      check("t2_rr_order", grant_log[k], (grant_log[0] + k) % NREQ);

    // 3: results stalled, 9 words offered
    stall_out = 1; src_left[2] = 9;
    n = 0; while (exp_q.size() < TD && n < 1500) begin @(negedge clk); n++; end
    check("t3_fill_in_time", n < 1500, 1);
    repeat (80) @(negedge clk);
    check("t3_outstanding", exp_q.size(), TD);
    check("t3_ready_blocked", bus.cli_ready, 0);
    check("t3_one_left", src_left[2], 1);
    check("t3_busy", bus.busy, 1);
    stall_out = 0;
    wait_drain("t3", 2000);

    // 4: heavy short-delay traffic so pushes and pops coincide
    maxd = 4; pp_cnt = 0; r0 = rsp_cnt;
    for (int i = 0; i < NREQ; i++) src_left[i] = 75;
    wait_drain("t4", 20000);
    check("t4_push_pop_seen", pp_cnt > 0, 1);
    check("t4_rsp_count", rsp_cnt - r0, 300);
    maxd = 20;

    // 5: reset during IN_REQ
    src_left[1] = 1;
    n = 0; while (bus.pipe_req_in !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    check("t5_req_in_up", bus.pipe_req_in, 1);
    rst = 1'b1; src_left[0] = 1; src_left[3] = 1;
    @(negedge clk);
    check("t5_cli_ready",  bus.cli_ready, 0);
    check("t5_req_in",     bus.pipe_req_in, 0);
    check("t5_ack_in",     bus.pipe_ack_in, 0);
    check("t5_rsp_valid",  bus.rsp_valid, 0);
    check("t5_data_in",    bus.pipe_data_in, 0);
    check("t5_rsp_data",   bus.rsp_data, 0);
    check("t5_pipe_rst_n", bus.pipe_rst_n, 0);
    check("t5_busy",       bus.busy, 0);
    @(negedge clk);
    rst = 1'b0;
    n = 0; while (grant_log.size() == 0 && n < 50) begin @(negedge clk); n++; end
    check("t5_first_grant", (grant_log.size() > 0) ? grant_log[0] : -1, 0);
    wait_drain("t5", 500);

    // 6: orphan result
    check("t6_err_before", bus.err_orphan, 0);
    r0 = rsp_cnt;
    inj_orphan = 1;
    n = 0; while (bus.pipe_ack_in !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    check("t6_ack_in_up", bus.pipe_ack_in, 1);
    n = 0; while (bus.pipe_ack_in !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    check("t6_ack_in_down", bus.pipe_ack_in, 0);
    repeat (5) @(negedge clk);
    check("t6_no_rsp", rsp_cnt - r0, 0);
    check("t6_err_orphan", bus.err_orphan, 1);
    check("t6_req_out_low", bus.pipe_req_out, 0);
    check("t6_busy_idle", bus.busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
